spi_frame_rx: RTL and testbench
===============================

# spi_frame_rx

Front end of the SPI configuration path. Brings the raw SCLK/COPI/nCS pins into the system clock domain and assembles 16-bit MSB-first frames. It validates each frame and hands completed write transactions to the register bank over a valid/ready interface. That register bank drives the PWM peripheral's enable and duty-cycle registers. Malformed frames and frames dropped on overrun are detected and reported.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for each pin; minimum 2.
- MAX_ADDR, 7'h04: highest register address forwarded when the address filter is compiled in.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  raw SPI clock pin, asynchronous to clk.
- copi  in  1  raw SPI data pin, asynchronous to clk.
- ncs  in  1  raw SPI chip select pin, active low, asynchronous to clk.
- wr_valid  out  1  write transaction held in the output buffer.
- wr_ready  in  1  consumer accepts the transaction when wr_valid and wr_ready are both high on a clk edge.
- wr_addr  out  7  register address, frame bits [14:8].
- wr_data  out  8  register data, frame bits [7:0].
- overrun  out  1  sticky; a valid write was dropped because the buffer was full.
- frame_err_cnt  out  8  saturating count of frames whose bit count was not 16.

## Operation
- Each pin passes through a SYNC_STAGES flop chain. One additional history flop per sclk and ncs supports edge detection.
- Frame format: bit15 is the R/W flag (1 = write), bits[14:8] are the address, bits[7:0] are the data. Bits are sent MSB first.
- States:
  - WAIT_IDLE: reset target. Moves to IDLE once synchronized ncs is high. This guarantees that a frame already in flight at reset is never captured.
  - IDLE: on synchronized ncs low, clear the shift register and the 5-bit bit counter, then go to SHIFT.
  - SHIFT: on each synchronized sclk rising edge, shift the synchronized copi into the LSB and increment the counter. The counter saturates at 31.
  - On synchronized ncs rising edge: evaluate the frame, then go to IDLE.
- Evaluation:
  - count != 16: increment frame_err_cnt, saturating at 255. The frame is discarded.
  - count == 16 and bit15 == 0: read frame. Silently discarded; it is not an error.
  - count == 16 and bit15 == 1: write frame. Load it into the one-entry output buffer and set wr_valid. If the buffer is still full, discard the frame and set overrun.
- Buffer: wr_valid clears on acceptance. wr_addr and wr_data stay stable while wr_valid is high.
- Simultaneous events:
  - Acceptance and a new valid write in the same cycle: the new frame loads, wr_valid stays high, and overrun is not set.
  - sclk and ncs edges detected in the same cycle: the ncs edge wins and the sclk edge is ignored.
- Reset values: wr_valid 0, wr_addr 0, wr_data 0, overrun 0, frame_err_cnt 0, state WAIT_IDLE. Synchronizer flops reset to 1 for ncs and 0 for sclk and copi.
- Reset mid-frame: the partial frame is discarded with no error count.

## Timing
- SPI mode 0. COPI is sampled on the SCLK rising edge.
- Each SCLK high phase and low phase must last at least SYNC_STAGES+1 clk periods. ncs must stay high for at least SYNC_STAGES+1 clk periods between frames.
- Latency: wr_valid rises on the (SYNC_STAGES+1)th clk edge after the ncs rise is first sampled.
- frame_err_cnt and overrun update on the same edge that wr_valid would have risen.
- Throughput: at most one frame per ncs cycle. No wr_ready backpressure reaches the SPI side.

## Configuration
- SPI_FRAME_RX_ADDR_FILTER_EN defined: a write frame with address > MAX_ADDR is discarded like a read frame. It does not raise wr_valid or overrun.
- Macro undefined: all 128 addresses are forwarded and MAX_ADDR is unused.

## Structure
- Package spi_rx_pkg holds:
  - FRAME_BITS = 16, ADDR_W = 7, DATA_W = 8.
  - Bit-index constants for the R/W flag, address field and data field.
  - The state enum: WAIT_IDLE, IDLE, SHIFT.
- Sub-module pin_sync: a parameterized SYNC_STAGES flop chain with a reset value parameter. It is instantiated three times.

## Test plan
- Write frame 0x8155 with wr_ready held high → one wr_valid pulse with wr_addr=0x01 and wr_data=0x55; frame_err_cnt stays 0.
- Read frame 0x0133 → wr_valid never rises and no counters change.
- Frames of 15 bits, then 17 bits, then 300 frames of 8 bits → frame_err_cnt reads 1, 2, then saturates at 255.
- wr_ready held low, send writes 0x8011 then 0x8122 → wr_addr=0x00 and wr_data=0x11 are held and overrun=1. Raise wr_ready in the same cycle a third frame 0x8233 completes → that frame loads and overrun stays 1.
- Assert rst after 8 bits of frame 0x84AA, release it while ncs is still low, finish the frame, then send 0x8203 → only the 0x8203 write appears (wr_addr=0x02, wr_data=0x03) and frame_err_cnt=0.
- With SPI_FRAME_RX_ADDR_FILTER_EN defined, send write 0x85FF → no wr_valid; then send write 0x84FF → wr_addr=0x04, wr_data=0xFF.

Source files
------------

// File: rtl/spi_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_pkg
// Description : Shared constants and state encoding for the SPI frame
//               receiver (frame geometry, field positions, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package spi_rx_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 5;

    // Field positions inside a completed frame (MSB first on the wire)
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

endpackage : spi_rx_pkg
`default_nettype wire

// File: rtl/spi_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_rx_if
// Description : Valid/ready write-transaction channel from the SPI receiver
//               (master) to the register bank (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_frame_rx_if;
    import spi_rx_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);

endinterface : spi_frame_rx_if
`default_nettype wire

// File: rtl/pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : pin_sync
// Description : STAGES-deep flop chain bringing one asynchronous pin into
//               the clk domain, with a configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw pin through the chain; the last stage is the synced value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule : pin_sync
`default_nettype wire

// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_rx
// Description : Synchronizes SCLK/COPI/nCS, assembles 16-bit MSB-first
//               frames, forwards write frames through a one-entry
//               valid/ready buffer, counts malformed frames and flags
//               overruns.
//               Optional feature macro: SPI_FRAME_RX_ADDR_FILTER_EN
//               (drops write frames whose address exceeds MAX_ADDR).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_rx
    import spi_rx_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR   = 7'h04
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           sclk,
    input  wire logic           copi,
    input  wire logic           ncs,
    spi_frame_rx_if.master      wr_if,
    output logic                overrun,
    output logic [7:0]          frame_err_cnt
);

`ifdef SPI_FRAME_RX_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // After reset the synchronizers hold their reset values, not the pins;
    // the FSM waits this many cycles so that a low nCS mid-frame is seen.
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    logic w_sclk_s;
    logic w_copi_s;
    logic w_ncs_s;

    pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk (clk), .rst (rst), .i_d (sclk), .o_q (w_sclk_s)
    );
    pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk (clk), .rst (rst), .i_d (copi), .o_q (w_copi_s)
    );
    pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk (clk), .rst (rst), .i_d (ncs), .o_q (w_ncs_s)
    );

    logic                  r_sclk_d;
    logic                  r_ncs_d;
    state_t                r_state;
    logic [FLUSH_W-1:0]    r_flush;
    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    logic w_sclk_rise;
    logic w_ncs_rise;
    logic w_frame_ok;
    logic w_is_write;
    logic w_addr_ok;
    logic w_accept;

    // History flops for edge detection on the synchronized sclk and ncs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_d <= 1'b0;
            r_ncs_d  <= 1'b1;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ncs_d  <= w_ncs_s;
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_ncs_rise  = w_ncs_s  & ~r_ncs_d;
    assign w_frame_ok  = (r_cnt == CNT_W'(FRAME_BITS));
    assign w_is_write  = r_shift[RW_BIT];
    assign w_addr_ok   = !FILTER_EN || (r_shift[ADDR_MSB:ADDR_LSB] <= MAX_ADDR);
    assign w_accept    = wr_if.wr_valid & wr_if.wr_ready;

    // Frame FSM: capture bits, evaluate on nCS rise, manage the output buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= WAIT_IDLE;
            r_flush        <= '0;
            r_shift        <= '0;
            r_cnt          <= '0;
            wr_if.wr_valid <= 1'b0;
            wr_if.wr_addr  <= '0;
            wr_if.wr_data  <= '0;
            overrun        <= 1'b0;
            frame_err_cnt  <= '0;
        end else begin
            // Consumer handshake; a same-cycle load below overrides this
            if (w_accept) begin
                wr_if.wr_valid <= 1'b0;
            end

            case (r_state)
                WAIT_IDLE: begin
                    if (r_flush != FLUSH_W'(SYNC_STAGES)) begin
                        r_flush <= r_flush + FLUSH_W'(1);
                    end else if (w_ncs_s) begin
                        r_state <= IDLE;
                    end
                end

                IDLE: begin
                    if (!w_ncs_s) begin
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    // The ncs edge takes priority over a coincident sclk edge
                    if (w_ncs_rise) begin
                        r_state <= IDLE;
                        if (!w_frame_ok) begin
                            if (frame_err_cnt != 8'hFF) begin
                                frame_err_cnt <= frame_err_cnt + 8'd1;
                            end
                        end else if (w_is_write && w_addr_ok) begin
                            if (wr_if.wr_valid && !w_accept) begin
                                overrun <= 1'b1;
                            end else begin
                                wr_if.wr_valid <= 1'b1;
                                wr_if.wr_addr  <= r_shift[ADDR_MSB:ADDR_LSB];
                                wr_if.wr_data  <= r_shift[DATA_MSB:DATA_LSB];
                            end
                        end
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_s};
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                default: r_state <= WAIT_IDLE;
            endcase
        end
    end

endmodule : spi_frame_rx
`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_rx
// Description : Directed self-checking bench for spi_frame_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_rx;
    import spi_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       overrun;
    logic [7:0] frame_err_cnt;

    int checks = 0;
    int errors = 0;

    spi_frame_rx_if wr_if ();

    spi_frame_rx #(
        .SYNC_STAGES (2),
        .MAX_ADDR    (7'h04)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sclk          (sclk),
        .copi          (copi),
        .ncs           (ncs),
        .wr_if         (wr_if),
        .overrun       (overrun),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        ncs = 1'b0;
        ticks(4);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            sclk = 1'b0;
            ticks(4);
            sclk = 1'b1;
            ticks(4);
            sclk = 1'b0;
        end
        ticks(4);
    endtask

    // Raise ncs and stop one edge short of the evaluation edge
    task automatic ncs_up_pre_eval();
        ncs = 1'b1;
        ticks(2);
    endtask

    // Full frame; returns just after the evaluation edge
    task automatic send_frame(input logic [31:0] v, input int n);
        start_frame();
        send_bits(v, n);
        ncs_up_pre_eval();
        tick();
    endtask

    initial begin
        wr_if.wr_ready = 1'b1;
        ticks(4);
        check("reset_valid",   32'(wr_if.wr_valid), 32'h0);
        check("reset_addr",    32'(wr_if.wr_addr),  32'h0);
        check("reset_data",    32'(wr_if.wr_data),  32'h0);
        check("reset_overrun", 32'(overrun),        32'h0);
        check("reset_errcnt",  32'(frame_err_cnt),  32'h0);
        rst = 1'b0;
        ticks(6);

        // Write 0x8155 with ready high: single-cycle valid pulse
        start_frame();
        send_bits(32'h8155, 16);
        ncs_up_pre_eval();
        check("w1_pre_valid", 32'(wr_if.wr_valid), 32'h0);
        tick();
        check("w1_valid", 32'(wr_if.wr_valid), 32'h1);
        check("w1_addr",  32'(wr_if.wr_addr),  32'h01);
        check("w1_data",  32'(wr_if.wr_data),  32'h55);
        tick();
        check("w1_pulse_end", 32'(wr_if.wr_valid), 32'h0);
        check("w1_errcnt",    32'(frame_err_cnt),  32'h0);
        ticks(2);

        // Read 0x0133: nothing forwarded, nothing counted
        send_frame(32'h0133, 16);
        check("rd_valid", 32'(wr_if.wr_valid), 32'h0);
        tick();
        check("rd_valid_late", 32'(wr_if.wr_valid), 32'h0);
        check("rd_errcnt",     32'(frame_err_cnt),  32'h0);
        check("rd_overrun",    32'(overrun),        32'h0);
        ticks(2);

        // Malformed frames: 15 bits, 17 bits, then many 8-bit frames
        send_frame(32'h7FFF, 15);
        check("err15_cnt",   32'(frame_err_cnt),  32'h1);
        check("err15_valid", 32'(wr_if.wr_valid), 32'h0);
        ticks(2);
        send_frame(32'h18155, 17);
        check("err17_cnt",   32'(frame_err_cnt),  32'h2);
        check("err17_valid", 32'(wr_if.wr_valid), 32'h0);
        ticks(2);
        for (int k = 0; k < 100; k++) begin
            send_frame(32'hA5, 8);
            ticks(2);
        end
        check("err_cnt_102", 32'(frame_err_cnt), 32'd102);
        for (int k = 0; k < 200; k++) begin
            send_frame(32'hA5, 8);
            ticks(2);
        end
        check("err_cnt_sat", 32'(frame_err_cnt), 32'd255);
        check("err_valid",   32'(wr_if.wr_valid), 32'h0);

        // Overrun with ready low, then accept+load in the same cycle
        wr_if.wr_ready = 1'b0;
        send_frame(32'h8011, 16);
        check("ov1_valid",   32'(wr_if.wr_valid), 32'h1);
        check("ov1_addr",    32'(wr_if.wr_addr),  32'h00);
        check("ov1_data",    32'(wr_if.wr_data),  32'h11);
        check("ov1_overrun", 32'(overrun),        32'h0);
        ticks(2);
        send_frame(32'h8122, 16);
        check("ov2_valid",   32'(wr_if.wr_valid), 32'h1);
        check("ov2_addr",    32'(wr_if.wr_addr),  32'h00);
        check("ov2_data",    32'(wr_if.wr_data),  32'h11);
        check("ov2_overrun", 32'(overrun),        32'h1);
        ticks(2);
        start_frame();
        send_bits(32'h8233, 16);
        ncs_up_pre_eval();
        wr_if.wr_ready = 1'b1;
        tick();
        check("ov3_valid",   32'(wr_if.wr_valid), 32'h1);
        check("ov3_addr",    32'(wr_if.wr_addr),  32'h02);
        check("ov3_data",    32'(wr_if.wr_data),  32'h33);
        check("ov3_overrun", 32'(overrun),        32'h1);
        tick();
        check("ov3_drained", 32'(wr_if.wr_valid), 32'h0);
        ticks(2);

        // Reset in the middle of frame 0x84AA
        start_frame();
        send_bits(32'h84, 8);
        rst = 1'b1;
        ticks(3);
        check("mid_rst_overrun", 32'(overrun),        32'h0);
        check("mid_rst_errcnt",  32'(frame_err_cnt),  32'h0);
        check("mid_rst_valid",   32'(wr_if.wr_valid), 32'h0);
        rst = 1'b0;
        send_bits(32'hAA, 8);
        ncs_up_pre_eval();
        tick();
        check("mid_tail_valid",  32'(wr_if.wr_valid), 32'h0);
        tick();
        check("mid_tail_valid2", 32'(wr_if.wr_valid), 32'h0);
        check("mid_tail_errcnt", 32'(frame_err_cnt),  32'h0);
        ticks(2);
        send_frame(32'h8203, 16);
        check("post_rst_valid",  32'(wr_if.wr_valid), 32'h1);
        check("post_rst_addr",   32'(wr_if.wr_addr),  32'h02);
        check("post_rst_data",   32'(wr_if.wr_data),  32'h03);
        check("post_rst_errcnt", 32'(frame_err_cnt),  32'h0);
        ticks(3);

`ifdef SPI_FRAME_RX_ADDR_FILTER_EN
        // Address above MAX_ADDR is dropped; MAX_ADDR itself passes
        send_frame(32'h85FF, 16);
        check("flt_drop_valid",   32'(wr_if.wr_valid), 32'h0);
        check("flt_drop_overrun", 32'(overrun),        32'h0);
        ticks(2);
        send_frame(32'h84FF, 16);
        check("flt_pass_valid", 32'(wr_if.wr_valid), 32'h1);
        check("flt_pass_addr",  32'(wr_if.wr_addr),  32'h04);
        check("flt_pass_data",  32'(wr_if.wr_data),  32'hFF);
`else
        // Without filtering, addresses above MAX_ADDR are forwarded
        send_frame(32'h85FF, 16);
        check("nf_valid", 32'(wr_if.wr_valid), 32'h1);
        check("nf_addr",  32'(wr_if.wr_addr),  32'h05);
        check("nf_data",  32'(wr_if.wr_data),  32'hFF);
        ticks(2);
        send_frame(32'hFF7E, 16);
        check("nf_hi_valid", 32'(wr_if.wr_valid), 32'h1);
        check("nf_hi_addr",  32'(wr_if.wr_addr),  32'h7F);
        check("nf_hi_data",  32'(wr_if.wr_data),  32'h7E);
`endif
        ticks(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_spi_frame_rx
`default_nettype wire
